// File: rtl/hazard_unit.sv
// Load-use hazard detector with branch flush; stalls the front end for STALL_CYCLES cycles per load-use hit.
// Control outputs are combinational from state and same-cycle inputs; the stall/flush counters update at the clock edge.
module hazard_unit #(
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ID_RF_r1,
    input  logic [2:0]  ID_RF_r2,
    input  logic        ID_uses_r1,
    input  logic        ID_uses_r2,
    input  logic        PR2_MEM_read,
    input  logic        PR2_RF_write_en,
    input  logic [2:0]  PR2_RF_dst,
    input  logic        EX_branch_taken,
    output logic        PC_write_en,
    output logic        PR1_write_en,
    output logic        PR1_flush,
    output logic        PR2_bubble,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;
    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        hazard;

    assign hazard = PR2_MEM_read & PR2_RF_write_en &
                    ((ID_uses_r1 & (ID_RF_r1 == PR2_RF_dst)) |
                     (ID_uses_r2 & (ID_RF_r2 == PR2_RF_dst)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_write_en  = 1'b1;
        PR1_write_en = 1'b1;
        PR1_flush    = 1'b0;
        PR2_bubble   = 1'b0;
        if (!rst) begin
            // Hold the pipeline frozen and empty while in reset.
            PC_write_en  = 1'b0;
            PR1_write_en = 1'b0;
            PR1_flush    = 1'b1;
            PR2_bubble   = 1'b1;
        end else if (EX_branch_taken) begin
            PR1_flush  = 1'b1;
            PR2_bubble = 1'b1;
            state_d    = RUN;
            cnt_d      = 3'd0;
        end else if (state_q == STALL) begin
            PC_write_en  = 1'b0;
            PR1_write_en = 1'b0;
            PR2_bubble   = 1'b1;
            cnt_d        = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (hazard) begin
            PC_write_en  = 1'b0;
            PR1_write_en = 1'b0;
            PR2_bubble   = 1'b1;
            // A single-cycle stall is fully covered by this RUN cycle.
            if (STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = STALL_LOAD;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!PC_write_en && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (PR1_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
